ram_gather: RTL and testbench
=============================

Name: ram_gather

Overview:
- Byte-serial load engine: reads 1, 2, 4 or 8 consecutive bytes from the byte-wide data RAM and assembles them little-endian into one 64-bit word.
- Applies zero or sign extension to the assembled word.
- Mirror of the byte-serial store path. It sits between the byte-wide RAM read port and the CPU register-file write-back, consuming the bytes the RAM produces.
- Runs its own small FSM, started by a one-cycle request from the control unit.

Parameters:
- AW, 16, RAM byte-address width.
- DW, 64, assembled result width (fixed at 64; other values unsupported).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load request, sampled only in IDLE
- size  input  2  00 = 1 byte, 01 = 2, 10 = 4, 11 = 8
- sgn  input  1  1 = sign-extend from top fetched byte, 0 = zero-extend
- addr  input  AW  base byte address
- ram_addr  output  AW  byte address to RAM read port
- ram_re  output  1  read enable to RAM
- ram_q  input  8  RAM read data (synchronous RAM, one-cycle read latency)
- busy  output  1  high from the start-accept edge until done
- done  output  1  one-cycle pulse, q valid
- q  output  DW  assembled, extended result, held until next done

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - ram_addr = 0, ram_re = 0, busy = 0, done = 0, q = 0.
  - Internal counters and accumulator cleared.
  - Reset mid-operation aborts the load with no done pulse; the first start after reset release is accepted normally.
- N = 1, 2, 4, 8 for size 00, 01, 10, 11.
- RAM contract: ram_addr/ram_re registered at edge E(c) are latched by the RAM at E(c+1); the byte is on ram_q during cycle c+1 and sampled by this block at E(c+2).
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start = 1 at edge E0: latch size, sgn; ram_addr <= addr; ram_re <= 1; busy <= 1; issue count <= 1; receive count <= 0; state <= FETCH.
  - done <= 0 on every IDLE edge without a completion.
- FETCH:
  - Each edge while issue count < N: ram_addr <= ram_addr + 1 (mod 2^AW wrap, 0xFFFF -> 0x0000), issue count += 1.
  - When issue count == N: ram_re <= 0, ram_addr holds, state <= DRAIN.
  - From E2 onward, each edge samples ram_q into accumulator byte lane [8*r+7 : 8*r], r = receive count, then r += 1.
  - For N = 1, FETCH lasts one edge.
- DRAIN:
  - Continues sampling until r == N.
  - The edge storing byte N-1 (edge E(N+1)) also loads q with the extended value and sets done <= 1, busy <= 0, state <= IDLE.
- Latency: start edge to done high = N+1 clock edges, i.e. 2, 3, 5, 9 for sizes 00..11.
- Extension: bits above 8N are filled with bit 8N-1 when sgn = 1, else 0. N = 8 ignores sgn.
- start while busy = 1: ignored, no queuing, latched fields unchanged.
- start in the same cycle done is high: accepted, since state is IDLE. Back-to-back loads therefore have a one-cycle gap.
- Accumulator lanes not written in the current load are treated as 0 before extension; stale bytes from earlier loads never leak into q.
- q changes only on a done edge or on reset.

Test Plan:
- RAM[0x0100..0x0107] = 81 22 33 44 55 66 77 88. Load 1 byte, sgn = 1, addr 0x0100 -> done 2 edges after start, q = 0xFFFF_FFFF_FFFF_FF81, ram_addr sequence 0x0100.
- Same RAM, 8 bytes, addr 0x0100 -> ram_addr 0x0100..0x0107 on consecutive cycles, ram_re high 8 cycles, done at edge 9, q = 0x8877_6655_4433_2281, busy high 9 cycles.
- Same RAM, 2 bytes sgn = 0, then 4 bytes sgn = 1 at addr 0x0104 -> q = 0x0000_0000_0000_2281, then q = 0xFFFF_FFFF_8877_6655; second start issued in the cycle the first done is high and accepted.
- Wrap: RAM[0xFFFF] = 0x12, RAM[0x0000] = 0x34, 2 bytes sgn = 1 at 0xFFFF -> ram_addr 0xFFFF then 0x0000, q = 0x0000_0000_0000_3412.
- start pulsed at cycles 1 and 3 of an 8-byte load -> second start ignored, single done at edge 9, q unchanged from the first request.
- rst_n low for 1 cycle during cycle 3 of a 4-byte load -> immediately busy = 0, ram_re = 0, q = 0, no done; a following 1-byte load completes in 2 edges.

Source files
------------

// File: rtl/ram_gather.sv
// Byte-serial load engine: fetches 1/2/4/8 bytes from a synchronous byte RAM,
// assembles them little-endian and zero/sign-extends the result to 64 bits.
module ram_gather #(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    size,
    input  logic          sgn,
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] ram_addr,
    output logic          ram_re,
    input  logic [7:0]    ram_q,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state, state_n;
    logic [AW-1:0] ram_addr_n;
    logic          ram_re_n, busy_n, done_n;
    logic [DW-1:0] q_n, acc, acc_n, acc_ins;
    logic [1:0]    size_r, size_n;
    logic          sgn_r, sgn_n;
    logic [3:0]    issue, issue_n, rcv, rcv_n;
    logic [3:0]    nbytes;
    logic          rd_pend;

    function automatic logic [DW-1:0] extend(input logic [DW-1:0] v,
                                             input logic [1:0] sz,
                                             input logic s);
        case (sz)
            2'd0:    extend = {{56{s & v[7]}},  v[7:0]};
            2'd1:    extend = {{48{s & v[15]}}, v[15:0]};
            2'd2:    extend = {{32{s & v[31]}}, v[31:0]};
            default: extend = v;
        endcase
    endfunction

    assign nbytes = 4'd1 << size_r;

    always_comb begin
        acc_ins = acc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (rcv[2:0] == i[2:0]) acc_ins[8*i +: 8] = ram_q;
        end
    end

    always_comb begin
        state_n    = state;
        ram_addr_n = ram_addr;
        ram_re_n   = ram_re;
        busy_n     = busy;
        done_n     = 1'b0;
        q_n        = q;
        size_n     = size_r;
        sgn_n      = sgn_r;
        issue_n    = issue;
        rcv_n      = rcv;
        acc_n      = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    size_n     = size;
                    sgn_n      = sgn;
                    ram_addr_n = addr;
                    ram_re_n   = 1'b1;
                    busy_n     = 1'b1;
                    issue_n    = 4'd1;
                    rcv_n      = '0;
                    acc_n      = '0;
                    state_n    = FETCH;
                end
            end
            FETCH, DRAIN: begin
                if (state == FETCH) begin
                    if (issue < nbytes) begin
                        ram_addr_n = ram_addr + AW'(1);
                        issue_n    = issue + 4'd1;
                    end else begin
                        ram_re_n = 1'b0;
                        state_n  = DRAIN;
                    end
                end
                // rd_pend marks the edge where the byte requested two edges ago is on ram_q
                if (rd_pend && (rcv < nbytes)) begin
                    acc_n = acc_ins;
                    rcv_n = rcv + 4'd1;
                    if (rcv == nbytes - 4'd1) begin
                        q_n     = extend(acc_ins, size_r, sgn_r);
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ram_addr <= '0;
            ram_re   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            size_r   <= '0;
            sgn_r    <= 1'b0;
            issue    <= '0;
            rcv      <= '0;
            acc      <= '0;
            rd_pend  <= 1'b0;
        end else begin
            state    <= state_n;
            ram_addr <= ram_addr_n;
            ram_re   <= ram_re_n;
            busy     <= busy_n;
            done     <= done_n;
            q        <= q_n;
            size_r   <= size_n;
            sgn_r    <= sgn_n;
            issue    <= issue_n;
            rcv      <= rcv_n;
            acc      <= acc_n;
            rd_pend  <= ram_re;
        end
    end

endmodule

// File: tb/tb_ram_gather.sv
// Self-checking bench for ram_gather: directed vector table, corner-case
// sequences and random loads against a byte-array reference model.
module tb_ram_gather;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    size = '0;
    logic          sgn = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic [7:0]    ram_q = '0;
    logic          busy;
    logic          done;
    logic [63:0]   q;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] expq;
    } vec_t;
    vec_t vecs [5];

    ram_gather #(.AW(AW), .DW(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .sgn(sgn),
        .addr(addr), .ram_addr(ram_addr), .ram_re(ram_re), .ram_q(ram_q),
        .busy(busy), .done(done), .q(q)
    );

    always #5 clk = ~clk;

    // synchronous RAM, one-cycle read latency
    always @(posedge clk) if (ram_re) ram_q <= mem[ram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [15:0] a, input logic [1:0] sz, input logic sg);
        int unsigned n = 1 << sz;
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < n; i++) v |= 64'(mem[16'(a + i)]) << (8 * i);
        if (sg && n < 8 && v[8*n-1]) v |= ~64'd0 << (8 * n);
        return v;
    endfunction

    // Call away from a clock edge; returns #1 after the done edge.
    task automatic run_load(input string name, input logic [15:0] a, input logic [1:0] sz,
                            input logic sg, input logic [63:0] expq, input int poke_at);
        int n = 1 << sz;
        int lat = 0, re_cnt = 0, busy_cnt = 0, bad_addr = 0;
        addr = a; size = sz; sgn = sg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (ram_re) begin
            if (ram_addr !== 16'(a + re_cnt)) bad_addr++;
            re_cnt++;
        end
        if (busy) busy_cnt++;
        while (lat < 20) begin
            if (poke_at != 0 && lat == poke_at) begin
                start = 1'b1; addr = a ^ 16'h00F0; size = 2'd0; sgn = ~sg;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (ram_re) begin
                if (ram_addr !== 16'(a + re_cnt)) bad_addr++;
                re_cnt++;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({name, "/latency"}, 64'(lat), 64'(n + 1));
        check({name, "/q"}, q, expq);
        check({name, "/re_cycles"}, 64'(re_cnt), 64'(n));
        check({name, "/addr_seq_errs"}, 64'(bad_addr), 64'd0);
        check({name, "/busy_cycles"}, 64'(busy_cnt), 64'(n + 1));
    endtask

    initial begin
        int dones;
        logic [63:0] hold_q;
        logic [15:0] ra;
        logic [1:0]  rsz;
        logic        rsg;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'h81; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
        mem[16'h0104] = 8'h55; mem[16'h0105] = 8'h66; mem[16'h0106] = 8'h77; mem[16'h0107] = 8'h88;
        mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;

        vecs[0] = '{"b1_sext",  16'h0100, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF81};
        vecs[1] = '{"b8",       16'h0100, 2'd3, 1'b0, 64'h8877_6655_4433_2281};
        vecs[2] = '{"b2_zext",  16'h0100, 2'd1, 1'b0, 64'h0000_0000_0000_2281};
        vecs[3] = '{"b4_sext",  16'h0104, 2'd2, 1'b1, 64'hFFFF_FFFF_8877_6655};
        vecs[4] = '{"wrap",     16'hFFFF, 2'd1, 1'b1, 64'h0000_0000_0000_3412};

        // reset state
        repeat (2) @(negedge clk);
        check("rst/ram_addr", 64'(ram_addr), 64'd0);
        check("rst/ram_re", 64'(ram_re), 64'd0);
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/done", 64'(done), 64'd0);
        check("rst/q", q, 64'd0);
        rst_n = 1'b1;

        // directed table, issued back-to-back (each start lands in the done cycle)
        @(negedge clk);
        for (int i = 0; i < 5; i++) run_load(vecs[i].name, vecs[i].a, vecs[i].sz, vecs[i].sg, vecs[i].expq, 0);

        // start while busy is ignored; done is a single pulse and q holds
        @(negedge clk);
        run_load("ignored", 16'h0100, 2'd3, 1'b0, 64'h8877_6655_4433_2281, 2);
        dones = 0;
        hold_q = q;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("ignored/extra_done", 64'(dones), 64'd0);
        check("ignored/q_hold", q, hold_q);

        // reset mid-load aborts without done
        @(negedge clk);
        addr = 16'h0100; size = 2'd2; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/ram_re", 64'(ram_re), 64'd0);
        check("abort/q", q, 64'd0);
        check("abort/done", 64'(done), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort/no_done", 64'(dones), 64'd0);
        @(negedge clk);
        run_load("after_abort", 16'h0100, 2'd0, 1'b0, 64'h81, 0);

        // random loads against the reference model
        for (int k = 0; k < 40; k++) begin
            ra  = ($urandom % 4 == 0) ? 16'(16'hFFFF - $urandom_range(0, 7)) : 16'($urandom);
            rsz = 2'($urandom);
            rsg = 1'($urandom);
            if ($urandom % 3 != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_load($sformatf("rand%0d", k), ra, rsz, rsg, model(ra, rsz, rsg), 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
